// File: rtl/sa_sync_pkg.sv
// Shared definitions for the synchronized-toggle event receive path:
// FSM state encoding and the default pending-counter width.
package sa_sync_pkg;

  localparam logic SA_SYNC_S_INIT = 1'b0;
  localparam logic SA_SYNC_S_RUN  = 1'b1;

  localparam int SA_SYNC_CNT_W = 4;

  typedef enum logic {
    S_INIT = SA_SYNC_S_INIT,
    S_RUN  = SA_SYNC_S_RUN
  } sa_sync_state_e;

endpackage

// File: rtl/sa_sync_evt_cnt.sv
// Saturating up/down pending-event counter. Simultaneous inc and dec cancel,
// so a full counter that receives both stays full without losing anything.
module sa_sync_evt_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!clr_) begin
      cnt_reg <= '0;
    end else if (inc && !dec && !sat) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (dec && !inc && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign sat = &cnt_reg;
  assign cnt = cnt_reg;

endmodule

// File: rtl/sa_sync_evt_rx.sv
// Converts a synchronized toggle level into queued events, hands them out
// through valid/ready, and returns one acknowledge toggle per accepted event.
module sa_sync_evt_rx
  import sa_sync_pkg::*;
#(
  parameter int CNT_W = SA_SYNC_CNT_W
) (
  input  logic             clk,
  input  logic             clr_,
  input  logic             sync_tgl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ack_tgl,
  output logic             ovf,
  input  logic             ovf_clr
);

  sa_sync_state_e   state_reg;
  sa_sync_state_e   state_next;
  logic             prev_reg;
  logic             ack_reg;
  logic             ovf_reg;
  logic             edge_det;
  logic             pop;
  logic             sat;
  logic             ovf_set;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr_) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:  state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // prev is loaded in S_INIT too, so a level already high at release is not an event
  always_ff @(posedge clk) begin
    if (!clr_) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= sync_tgl;
    end
  end

  assign edge_det  = (state_reg == S_RUN) && (sync_tgl ^ prev_reg);
  assign evt_valid = (cnt != '0);
  assign pop       = evt_valid && evt_ready;
  assign ovf_set   = edge_det && !pop && sat;

  sa_sync_evt_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .clr_(clr_),
    .inc (edge_det),
    .dec (pop),
    .cnt (cnt),
    .sat (sat)
  );

  always_ff @(posedge clk) begin
    if (!clr_) begin
      ack_reg <= 1'b0;
    end else if (pop) begin
      ack_reg <= ~ack_reg;
    end
  end

  // a loss in the same cycle as a clear must remain visible
  always_ff @(posedge clk) begin
    if (!clr_) begin
      ovf_reg <= 1'b0;
    end else if (ovf_set) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign evt_cnt = cnt;
  assign ack_tgl = ack_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_sa_sync_evt_rx.sv
// Drives a 4-bit and a 2-bit counter instance from the same stimulus; checks a
// hand-computed vector table, then random traffic against a pending-count model.
module tb_sa_sync_evt_rx;

  logic       clk = 1'b0;
  logic       clr_ = 1'b0;
  logic       sync_tgl = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       valid4, ack4, ovf4;
  logic [3:0] cnt4;
  logic       valid2, ack2, ovf2;
  logic [1:0] cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sa_sync_evt_rx #(.CNT_W(4)) dut4 (
    .clk(clk), .clr_(clr_), .sync_tgl(sync_tgl), .evt_valid(valid4),
    .evt_ready(evt_ready), .evt_cnt(cnt4), .ack_tgl(ack4), .ovf(ovf4),
    .ovf_clr(ovf_clr)
  );

  sa_sync_evt_rx #(.CNT_W(2)) dut2 (
    .clk(clk), .clr_(clr_), .sync_tgl(sync_tgl), .evt_valid(valid2),
    .evt_ready(evt_ready), .evt_cnt(cnt2), .ack_tgl(ack2), .ovf(ovf2),
    .ovf_clr(ovf_clr)
  );

  // Reference model: pending events as a plain integer, clamped at capacity.
  int m_max [2] = '{15, 3};
  int m_pend[2];
  bit m_ack [2];
  bit m_ovf [2];
  bit m_armed;
  bit m_last;

  task automatic model_step(input bit c, input bit s, input bit r, input bit o);
    for (int i = 0; i < 2; i++) begin
      bit ev, pp, lost;
      if (!c) begin
        m_pend[i] = 0;
        m_ack[i]  = 0;
        m_ovf[i]  = 0;
      end else begin
        ev   = m_armed && (s != m_last);
        pp   = (m_pend[i] > 0) && r;
        lost = 0;
        if (ev && !pp) begin
          if (m_pend[i] < m_max[i]) m_pend[i] = m_pend[i] + 1;
          else lost = 1;
        end else if (pp && !ev) begin
          m_pend[i] = m_pend[i] - 1;
        end
        if (pp) m_ack[i] = !m_ack[i];
        if (lost) m_ovf[i] = 1;
        else if (o) m_ovf[i] = 0;
      end
    end
    if (!c) begin
      m_armed = 0;
      m_last  = 0;
    end else begin
      m_armed = 1;
      m_last  = s;
    end
  endtask

  // apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input bit c, input bit s, input bit r, input bit o);
    clr_      = c;
    sync_tgl  = s;
    evt_ready = r;
    ovf_clr   = o;
    model_step(c, s, r, o);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit c, s, r, o;
    int c4, a4, o4;
    int c2, a2, o2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit s, bit r, bit o,
                              int c4, int a4, int o4, int c2, int a2, int o2);
    vec_t v;
    v.c = c; v.s = s; v.r = r; v.o = o;
    v.c4 = c4; v.a4 = a4; v.o4 = o4;
    v.c2 = c2; v.a2 = a2; v.o2 = o2;
    return v;
  endfunction

  initial begin
    //               c  s  r  o   c4 a4 o4  c2 a2 o2
    // fresh reset with level 0, then a single 0->1 toggle with ready high
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  1, 0, 0,  1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  0, 1, 0,  0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0,  0, 1, 0,  0, 1, 0));
    // backpressure: five toggles on consecutive cycles, 2-bit copy saturates
    tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0,  1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0,  2, 1, 0,  2, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  3, 1, 0,  3, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0,  4, 1, 0,  3, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0,  5, 1, 0,  3, 1, 1));
    // ovf_clr alone, then ovf_clr together with an overflowing edge, then alone
    tbl.push_back(mk(1, 0, 0, 1,  5, 1, 0,  3, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1,  6, 1, 0,  3, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1,  6, 1, 0,  3, 1, 0));
    // edge and pop together with the 2-bit copy full
    tbl.push_back(mk(1, 0, 1, 0,  6, 0, 0,  3, 0, 0));
    // drain
    tbl.push_back(mk(1, 0, 1, 0,  5, 1, 0,  2, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,  4, 0, 0,  1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  3, 1, 0,  0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,  2, 0, 0,  0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,  1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,  0, 0, 0,  0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0,  0, 0, 0,  0, 1, 0));
    // build cnt=2, reset mid-operation, first released cycle counts nothing
    tbl.push_back(mk(1, 1, 0, 0,  1, 0, 0,  1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2, 0, 0,  2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0,  0, 0, 0));

    // reset baseline with the level held high through reset
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rst_valid4", valid4, 0);
    chk("rst_cnt4", cnt4, 0);
    chk("rst_ack4", ack4, 0);
    chk("rst_ovf4", ovf4, 0);
    chk("rst_valid2", valid2, 0);
    chk("rst_ack2", ack2, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 0, 0);
      chk("base_valid4", valid4, 0);
      chk("base_cnt4", cnt4, 0);
      chk("base_valid2", valid2, 0);
      chk("base_cnt2", cnt2, 0);
    end
    $display("baseline: 10 idle cycles after release, cnt4=%0d cnt2=%0d", cnt4, cnt2);

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      cyc(v.c, v.s, v.r, v.o);
      chk($sformatf("v%0d_cnt4", k), cnt4, v.c4);
      chk($sformatf("v%0d_valid4", k), valid4, (v.c4 != 0) ? 1 : 0);
      chk($sformatf("v%0d_ack4", k), ack4, v.a4);
      chk($sformatf("v%0d_ovf4", k), ovf4, v.o4);
      chk($sformatf("v%0d_cnt2", k), cnt2, v.c2);
      chk($sformatf("v%0d_valid2", k), valid2, (v.c2 != 0) ? 1 : 0);
      chk($sformatf("v%0d_ack2", k), ack2, v.a2);
      chk($sformatf("v%0d_ovf2", k), ovf2, v.o2);
      $display("vec %0d: clr_=%0b tgl=%0b rdy=%0b oclr=%0b -> cnt4=%0d ack4=%0b ovf4=%0b cnt2=%0d ack2=%0b ovf2=%0b",
               k, v.c, v.s, v.r, v.o, cnt4, ack4, ovf4, cnt2, ack2, ovf2);
    end

    for (int k = 0; k < 3000; k++) begin
      bit c, s, r, o;
      c = ($urandom_range(0, 99) != 0);
      s = $urandom_range(0, 1);
      r = (k % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 15) == 0);
      cyc(c, s, r, o);
      chk("rnd_cnt4", cnt4, m_pend[0]);
      chk("rnd_valid4", valid4, (m_pend[0] != 0) ? 1 : 0);
      chk("rnd_ack4", ack4, m_ack[0]);
      chk("rnd_ovf4", ovf4, m_ovf[0]);
      chk("rnd_cnt2", cnt2, m_pend[1]);
      chk("rnd_valid2", valid2, (m_pend[1] != 0) ? 1 : 0);
      chk("rnd_ack2", ack2, m_ack[1]);
      chk("rnd_ovf2", ovf2, m_ovf[1]);
      $display("rnd %0d: clr_=%0b tgl=%0b rdy=%0b oclr=%0b -> cnt4=%0d/%0d cnt2=%0d/%0d ovf2=%0b",
               k, c, s, r, o, cnt4, m_pend[0], cnt2, m_pend[1], ovf2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
